// File: rtl/display_scan_controller_pkg.sv
// Shared constants, types and the per-slot scan helper for the display scan controller.
package display_scan_controller_pkg;

  localparam int unsigned N_DIGITS            = 8;
  localparam int unsigned IDX_W               = 3;
  localparam int unsigned NIB_W               = 4;
  localparam int unsigned DATA_W              = N_DIGITS * NIB_W;
  localparam int unsigned REFRESH_DIV_DEFAULT = 100000;

  localparam logic [N_DIGITS-1:0] ANODE_OFF = 8'hFF;
  // Index sits on the last digit in reset so the first tick lands on digit 0.
  localparam logic [IDX_W-1:0]    IDX_RESET = IDX_W'(N_DIGITS - 1);

  typedef logic [IDX_W-1:0] digit_idx_t;
  typedef logic [NIB_W-1:0] nibble_t;

  // Registered output pair for one digit slot.
  typedef struct packed {
    logic [N_DIGITS-1:0] anode;
    nibble_t             hex;
  } scan_out_t;

  // Anode pattern and nibble for digit idx of word, including leading-zero blanking.
  function automatic scan_out_t scan_slot(input logic [DATA_W-1:0] word,
                                          input digit_idx_t        idx,
                                          input logic              enable,
                                          input logic              blank_lz);
    logic [DATA_W-1:0] upper;
    logic              hidden;
    scan_out_t         s;
    // upper holds word[31:4*idx] right-aligned; a zero value means this digit leads with zeros
    upper   = word >> {idx, 2'b00};
    hidden  = blank_lz && (idx != '0) && (upper == '0);
    s.hex   = upper[NIB_W-1:0];
    s.anode = (enable && !hidden) ? ~(N_DIGITS'(1) << idx) : ANODE_OFF;
    return s;
  endfunction

endpackage

// File: rtl/display_scan_controller_refresh_prescaler.sv
// Free-running divider producing one tick every DIV clocks.
module refresh_prescaler
  import display_scan_controller_pkg::*;
#(
  parameter int unsigned DIV = REFRESH_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Tick is valid for the whole cycle in which the counter holds its terminal value.
  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/display_scan_controller.sv
// Eight-digit multiplexed display scanner with frame-aligned data commit.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                load,
  input  logic                enable,
  input  logic                blank_lz,
  output logic [NIB_W-1:0]    hex_out,
  output logic [N_DIGITS-1:0] anode,
  output logic                load_ack
);

  logic              tick;
  digit_idx_t        idx;
  digit_idx_t        idx_nxt;
  logic [DATA_W-1:0] display;
  logic [DATA_W-1:0] display_nxt;
  logic [DATA_W-1:0] pending;
  logic              pending_valid;
  logic              commit;
  scan_out_t         slot_nxt;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Next digit, commit decision and the slot the outputs will show after this tick.
  always_comb begin
    idx_nxt     = idx + IDX_W'(1);
    commit      = 1'b0;
    display_nxt = display;
    if (tick && (idx_nxt == '0) && pending_valid) begin
      commit      = 1'b1;
      display_nxt = pending;
    end
    slot_nxt = scan_slot(display_nxt, idx_nxt, enable, blank_lz);
  end

  // Digit index and displayed word; the word only moves on the wrap to digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= IDX_RESET;
      display <= '0;
    end else begin
      if (tick) begin
        idx <= idx_nxt;
      end
      if (commit) begin
        display <= pending;
      end
    end
  end

  // Pending buffer; a load in the commit cycle refills it after the old value is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (load) begin
      pending       <= data_in;
      pending_valid <= 1'b1;
    end else if (commit) begin
      pending_valid <= 1'b0;
    end
  end

  // Registered scan outputs and the commit acknowledge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode    <= ANODE_OFF;
      hex_out  <= '0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= commit;
      if (tick) begin
        anode   <= slot_nxt.anode;
        hex_out <= slot_nxt.hex;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed self-checking bench for display_scan_controller with REFRESH_DIV=4.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = '0;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic        blank_lz = 1'b0;
  logic [3:0]  hex_out;
  logic [7:0]  anode;
  logic        load_ack;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_cnt = 0;
  logic [7:0]  s_an;
  logic [3:0]  s_hx;
  logic        s_ack;

  display_scan_controller #(
    .REFRESH_DIV (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .enable   (enable),
    .blank_lz (blank_lz),
    .hex_out  (hex_out),
    .anode    (anode),
    .load_ack (load_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] an_of(input int k);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << k);
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] v, input int k);
    logic [31:0] s;
    s = v >> (4 * k);
    return s[3:0];
  endfunction

  // Run one 4-clock digit slot (optionally pulsing load before edge ld_at), sample after the tick edge.
  task automatic slot(input logic ld, input int ld_at, input logic [31:0] d);
    for (int e = 0; e < 4; e++) begin
      if (ld && e == ld_at) begin
        data_in = d;
        load    = 1'b1;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      @(negedge clk);
      if (load_ack) ack_cnt++;
    end
    s_an  = anode;
    s_hx  = hex_out;
    s_ack = load_ack;
  endtask

  task automatic check_slot(input string tag, input logic [7:0] ean, input logic [3:0] ehx,
                            input logic eack);
    check({tag, ".anode"}, 32'(s_an), 32'(ean));
    check({tag, ".hex"}, 32'(s_hx), 32'(ehx));
    check({tag, ".ack"}, 32'(s_ack), 32'(eack));
  endtask

  initial begin
    logic [3:0] exp28 [8];
    exp28 = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};

    // Reset values
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.anode", 32'(anode), 32'hFF);
    check("rst.hex", 32'(hex_out), 32'h0);
    check("rst.ack", 32'(load_ack), 32'h0);
    reset = 1'b0;

    // Plain scan: first change 4 clocks after release, one digit per 4 clocks
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("scan.e%0d", e), 32'(anode), 32'((e < 4) ? 8'hFF : an_of(e / 4 - 1)));
    end
    check("scan.hex", 32'(hex_out), 32'h0);

    // Mid-frame load commits only at digit 0
    ack_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("ld.pre%0d", k), an_of(k), 4'h0, 1'b0);
    end
    slot(1'b1, 0, 32'h1234ABCD);
    check_slot("ld.d3", an_of(3), 4'h0, 1'b0);
    for (int k = 4; k < 8; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("ld.wait%0d", k), an_of(k), 4'h0, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("ld.show%0d", k), an_of(k), exp28[k], k == 0);
    end
    check("ld.acks", 32'(ack_cnt), 32'd1);

    // Two loads in one frame: latest wins, single ack
    ack_cnt = 0;
    slot(1'b0, 0, '0);
    check_slot("dbl.d0", an_of(0), 4'hD, 1'b0);
    slot(1'b1, 0, 32'h11111111);
    check_slot("dbl.d1", an_of(1), 4'hC, 1'b0);
    slot(1'b1, 0, 32'h22222222);
    check_slot("dbl.d2", an_of(2), 4'hB, 1'b0);
    for (int k = 3; k < 8; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("dbl.old%0d", k), an_of(k), nib(32'h1234ABCD, k), 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("dbl.new%0d", k), an_of(k), 4'h2, k == 0);
    end
    check("dbl.acks", 32'(ack_cnt), 32'd1);

    // Leading-zero blanking
    blank_lz = 1'b1;
    ack_cnt = 0;
    slot(1'b1, 0, 32'h000000A0);
    check_slot("blz.d0", 8'hFE, 4'h0, 1'b1);
    slot(1'b0, 0, '0);
    check_slot("blz.d1", 8'hFD, 4'hA, 1'b0);
    for (int k = 2; k < 8; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("blz.d%0d", k), 8'hFF, 4'h0, 1'b0);
    end
    slot(1'b1, 0, 32'h0);
    check_slot("blz0.d0", 8'hFE, 4'h0, 1'b1);
    for (int k = 1; k < 8; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("blz0.d%0d", k), 8'hFF, 4'h0, 1'b0);
    end
    check("blz.acks", 32'(ack_cnt), 32'd2);
    blank_lz = 1'b0;

    // Load in the commit cycle: old pending shown now, new one next frame
    ack_cnt = 0;
    slot(1'b0, 0, '0);
    check_slot("cc.d0", an_of(0), 4'h0, 1'b0);
    slot(1'b1, 0, 32'h00000005);
    check_slot("cc.d1", an_of(1), 4'h0, 1'b0);
    for (int k = 2; k < 8; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("cc.w%0d", k), an_of(k), 4'h0, 1'b0);
    end
    slot(1'b1, 3, 32'h00000077);
    check_slot("cc.f1d0", 8'hFE, 4'h5, 1'b1);
    for (int k = 1; k < 8; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("cc.f1d%0d", k), an_of(k), 4'h0, 1'b0);
    end
    slot(1'b0, 0, '0);
    check_slot("cc.f2d0", 8'hFE, 4'h7, 1'b1);
    slot(1'b0, 0, '0);
    check_slot("cc.f2d1", 8'hFD, 4'h7, 1'b0);
    check("cc.acks", 32'(ack_cnt), 32'd2);

    // enable=0 for a frame: anodes dark, index and nibble keep moving
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("en.i%0d", i), 8'hFF, nib(32'h77, (i + 2) % 8), 1'b0);
    end
    enable = 1'b1;
    slot(1'b0, 0, '0);
    check_slot("en.back", 8'hFB, 4'h0, 1'b0);

    // Reset mid-frame with pending data: immediate clear, pending discarded
    slot(1'b1, 0, 32'hFFFFFFFF);
    check_slot("mr.pre", 8'hF7, 4'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mr.anode", 32'(anode), 32'hFF);
    check("mr.hex", 32'(hex_out), 32'h0);
    check("mr.ack", 32'(load_ack), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ack_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      slot(1'b0, 0, '0);
      check_slot($sformatf("mr.d%0d", k), an_of(k), 4'h0, 1'b0);
    end
    check("mr.acks", 32'(ack_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_in  input  32  eight hex nibbles; nibble k = data_in[4k+3:4k] drives digit k, digit 0 rightmost.
REQ-005 SHALL have port load  input  1  one-cycle strobe capturing data_in into the pending register.
REQ-006 SHALL have port enable  input  1  0 = all anodes off while scanning continues.
REQ-007 SHALL have port blank_lz  input  1  1 = leading-zero digits blanked.
REQ-008 SHALL have port hex_out  output  4  nibble of the active digit, fed to the downstream hex-to-7-segment decoder.
REQ-009 SHALL have port anode  output  8  active-low digit enables, one-cold when lit.
REQ-010 SHALL have port load_ack  output  1  one-cycle pulse when pending data commits to the display.

Function
REQ-011 Prescaler: counter 0..REFRESH_DIV-1, wraps to 0; tick asserted in the cycle the counter equals REFRESH_DIV-1.
REQ-012 Digit index: 3-bit, advances modulo 8 on tick only; 7 -> 0 is a frame boundary.
REQ-013 hex_out and anode registered, updated only on tick, both from the new index; output latency one clk after the tick cycle.
REQ-014 Lit digit: anode[idx]=0, all other bits 1; digit hidden -> anode=8'hFF, hex_out still carries the nibble.
REQ-015 load: pending <= data_in, pending_valid <= 1; a second load before commit overwrites, latest wins.
REQ-016 Commit: on the tick whose new index is 0 with pending_valid=1 -> display <= pending, pending_valid <= 0, load_ack=1 for exactly that cycle; hex_out for digit 0 taken from the committed value.
REQ-017 Load and commit in the same cycle: commit uses the pending value from before the cycle; the new load becomes pending with pending_valid=1.
REQ-018 Display register changes only at frame boundaries; no frame mixes old and new nibbles.
REQ-019 Leading-zero blanking: digit k hidden when blank_lz=1 and display[31:4k] == 0 for k>=1; digit 0 never blanked.
REQ-020 enable=0 forces anode=8'hFF at the next tick; prescaler, index, load and commit unaffected.

Reset
REQ-021 reset SHALL immediately clear: prescaler 0, index 7, display 0, pending 0, pending_valid 0.
REQ-022 Output reset values SHALL be: anode=8'hFF, hex_out=4'h0, load_ack=0.
REQ-023 First tick after reset release SHALL light digit 0; reset mid-frame or mid-pending discards pending data with no load_ack.

Structure
REQ-024 A shared package SHALL hold N_DIGITS=8, the ANODE_OFF=8'hFF constant and the default REFRESH_DIV.
REQ-025 Prescaler SHALL be the single sub-module refresh_prescaler (parameter DIV, output tick); the remaining logic stays flat.
REQ-026 hex_to_7segment SHALL be instantiated by the top level, not inside this block.

Verification (REFRESH_DIV=4)
REQ-027 Reset, then 32 clocks -> anode sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 clocks, first change 4 clocks after release.
REQ-028 load data_in=32'h1234ABCD mid-frame -> no change until index 0; then load_ack for 1 cycle, hex_out per slot D,C,B,A,4,3,2,1.
REQ-029 Two loads (32'h11111111, then 32'h22222222) in one frame -> single load_ack, all digits show 2.
REQ-030 blank_lz=1, display=32'h000000A0 -> digits 0,1 lit (hex_out 0 then A), digits 2-7 anode=FF; display=0 -> only digit 0 lit showing 0.
REQ-031 load asserted in the commit cycle with pending 32'h5 -> 5 shown this frame, new value next frame, two load_ack pulses total.
REQ-032 enable=0 for one frame -> anode=FF all frame, index keeps advancing; reset asserted mid-frame -> anode=FF and hex_out=0 within the same cycle, no load_ack.
